// File: rtl/d2b_display_pkg.sv
// Shared constants, segment encoder and converter state type for the
// decimal-to-binary game display.
package d2b_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for decimal 0..9; index 0 is leftmost
  localparam logic [0:9][6:0] SEG_CODES = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_e;

  // Non-decimal codes fall back to a dark digit rather than a garbage glyph
  function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
    logic [6:0] seg;
    seg = BLANK_SEG;
    if (bcd <= 4'd9) seg = SEG_CODES[bcd];
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. Captures number/level, converts the
// number over ten steps and publishes all eight digits plus blank flags in a
// single commit cycle so the display never sees half-converted values.
module bin2bcd_seq
  import d2b_display_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                number_i,
  input  logic [3:0]                level_i,
  output logic [NUM_DIGITS*4-1:0]   digit_bcd_o,
  output logic [NUM_DIGITS-1:0]     digit_blank_o
);

  // Power-up picture is number 0 / level 0: only digits 0 and 6 are lit
  localparam logic [NUM_DIGITS-1:0] RESET_BLANK = 8'b1011_1110;

  conv_state_e               state_q;
  logic [9:0]                src_num_q;
  logic [9:0]                num_sh_q;
  logic [3:0]                src_lvl_q;
  logic [15:0]               bcd_q;
  logic [3:0]                step_q;
  logic [NUM_DIGITS*4-1:0]   shown_bcd_q;
  logic [NUM_DIGITS-1:0]     shown_blank_q;

  logic [15:0]               bcd_adj_d;
  logic [15:0]               bcd_step_d;
  logic                      lvl_tens_d;
  logic [3:0]                lvl_ones_d;
  logic [2:0]                num_blank_d;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign bcd_adj_d[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  // Next MSB of the captured number enters at the bottom of the BCD register
  assign bcd_step_d = {bcd_adj_d[14:0], num_sh_q[9]};

  // Level never exceeds 15, so a single compare gives the tens digit
  assign lvl_tens_d = (src_lvl_q >= 4'd10);
  assign lvl_ones_d = lvl_tens_d ? src_lvl_q - 4'd10 : src_lvl_q;

  // Leading-zero blanking for number digits 3..1; digit 0 always shows
  assign num_blank_d[2] = (bcd_q[15:12] == 4'd0);
  assign num_blank_d[1] = num_blank_d[2] && (bcd_q[11:8] == 4'd0);
  assign num_blank_d[0] = num_blank_d[1] && (bcd_q[7:4] == 4'd0);

  // Capture / convert / commit sequencer; an input change mid-conversion is
  // picked up by the IDLE compare once the current result has been committed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      src_num_q     <= '0;
      num_sh_q      <= '0;
      src_lvl_q     <= '0;
      bcd_q         <= '0;
      step_q        <= '0;
      shown_bcd_q   <= '0;
      shown_blank_q <= RESET_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          if (number_i != src_num_q || level_i != src_lvl_q) begin
            src_num_q <= number_i;
            num_sh_q  <= number_i;
            src_lvl_q <= level_i;
            bcd_q     <= '0;
            step_q    <= '0;
            state_q   <= CONVERT;
          end
        end
        CONVERT: begin
          if (step_q == 4'd10) begin
            state_q <= COMMIT;
          end else begin
            bcd_q    <= bcd_step_d;
            num_sh_q <= {num_sh_q[8:0], 1'b0};
            step_q   <= step_q + 4'd1;
          end
        end
        COMMIT: begin
          shown_bcd_q   <= {3'b000, lvl_tens_d, lvl_ones_d, 8'h00, bcd_q};
          shown_blank_q <= {~lvl_tens_d, 1'b0, 2'b11, num_blank_d, 1'b0};
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit_bcd_o   = shown_bcd_q;
  assign digit_blank_o = shown_blank_q;

endmodule

// File: rtl/seven_seg_bcd_driver.sv
// Eight-digit active-low seven-segment scanner for the game display: number
// on digits 3..0, level on digits 7..6, with a dark guard cycle between slots.
module seven_seg_bcd_driver
  import d2b_display_pkg::*;
#(
  parameter int SCAN_DIV = 12500
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             number,
  input  logic [3:0]             level,
  output logic [NUM_DIGITS-1:0]  anode,
  output logic [6:0]             cathode
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]          div_q;
  logic [2:0]                slot_q;
  logic [NUM_DIGITS-1:0]     anode_q;
  logic [6:0]                cathode_q;

  logic [NUM_DIGITS*4-1:0]   digit_bcd;
  logic [NUM_DIGITS-1:0]     digit_blank;
  logic [6:0]                seg_all [NUM_DIGITS];
  logic                      div_last_d;

  bin2bcd_seq u_bin2bcd (
    .clk           (clk),
    .reset         (reset),
    .number_i      (number),
    .level_i       (level),
    .digit_bcd_o   (digit_bcd),
    .digit_blank_o (digit_blank)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      assign seg_all[gi] = digit_blank[gi] ? BLANK_SEG : seg_encode(digit_bcd[gi*4 +: 4]);
    end
  endgenerate

  assign div_last_d = (div_q == DIV_LAST);

  // Free-running slot timer; the slot advances on the divider's terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      slot_q <= '0;
    end else if (div_last_d) begin
      div_q  <= '0;
      slot_q <= slot_q + 3'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Registered drive: dark on the terminal-count cycle and for blanked digits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anode_q   <= '1;
      cathode_q <= BLANK_SEG;
    end else if (div_last_d || digit_blank[slot_q]) begin
      anode_q   <= '1;
      cathode_q <= BLANK_SEG;
    end else begin
      anode_q   <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << slot_q);
      cathode_q <= seg_all[slot_q];
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_seven_seg_bcd_driver.sv
// Self-checking bench: a cycle-level behavioural model of what the display
// must show, compared on every falling edge, plus literal digit checks.
module tb_seven_seg_bcd_driver;

  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] number;
  logic [3:0] level;
  logic [7:0] anode;
  logic [6:0] cathode;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  seven_seg_bcd_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .number  (number),
    .level   (level),
    .anode   (anode),
    .cathode (cathode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digit shown in slot s for number n / level l, or -1 when dark
  function automatic int digit_val(input int s, input int n, input int l);
    case (s)
      0:       return n % 10;
      1:       return (n < 10)   ? -1 : (n / 10) % 10;
      2:       return (n < 100)  ? -1 : (n / 100) % 10;
      3:       return (n < 1000) ? -1 : n / 1000;
      6:       return l % 10;
      7:       return (l < 10)   ? -1 : l / 10;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] model_anode(input int e, input int n, input int l);
    int slot;
    slot = (e / SCAN_DIV) % 8;
    if ((e % SCAN_DIV) == SCAN_DIV - 1 || digit_val(slot, n, l) < 0) return 8'hFF;
    return ~(8'h01 << slot);
  endfunction

  function automatic logic [6:0] model_cathode(input int e, input int n, input int l);
    int slot;
    int v;
    slot = (e / SCAN_DIV) % 8;
    v = digit_val(slot, n, l);
    if ((e % SCAN_DIV) == SCAN_DIV - 1 || v < 0) return 7'h7F;
    return SEG_TAB[v];
  endfunction

  // Behavioural model: e counts edges since reset release; a change seen while
  // idle becomes visible on the shown value exactly 12 edges later
  logic [7:0] exp_anode   = 8'hFF;
  logic [6:0] exp_cathode = 7'h7F;
  int e_m = 0, shown_num = 0, shown_lvl = 0, src_num_m = 0, src_lvl_m = 0, cdown = 0;
  bit busy = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_anode   <= 8'hFF;
      exp_cathode <= 7'h7F;
      e_m         <= 0;
      shown_num   <= 0;
      shown_lvl   <= 0;
      src_num_m   <= 0;
      src_lvl_m   <= 0;
      cdown       <= 0;
      busy        <= 1'b0;
    end else begin
      exp_anode   <= model_anode(e_m, shown_num, shown_lvl);
      exp_cathode <= model_cathode(e_m, shown_num, shown_lvl);
      e_m         <= e_m + 1;
      if (!busy) begin
        if (int'(number) != src_num_m || int'(level) != src_lvl_m) begin
          src_num_m <= int'(number);
          src_lvl_m <= int'(level);
          busy      <= 1'b1;
          cdown     <= 12;
        end
      end else if (cdown == 1) begin
        shown_num <= src_num_m;
        shown_lvl <= src_lvl_m;
        busy      <= 1'b0;
      end else begin
        cdown <= cdown - 1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("model_anode", int'(anode), int'(exp_anode));
      check("model_cathode", int'(cathode), int'(exp_cathode));
    end
  end

  // Wait (bounded) for a given anode pattern, then pin its cathode literally
  task automatic expect_digit(input string name, input logic [7:0] an, input logic [6:0] cat);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (anode == an) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s: anode %h never seen (last %h), required %h", name, an, anode, an);
    end else begin
      check(name, int'(cathode), int'(cat));
    end
  endtask

  // Over one full frame, the anode bits in mask must never go low
  task automatic expect_dark(input string name, input logic [7:0] mask);
    int lit;
    lit = 0;
    repeat (8 * SCAN_DIV) begin
      @(negedge clk);
      if ((~anode & mask) != 8'h00) lit++;
    end
    check(name, lit, 0);
  endtask

  localparam int NUM_PICKS [0:7] = '{0, 9, 10, 99, 100, 999, 1000, 1023};

  initial begin
    int hold;
    reset  = 1'b0;
    number = 10'd0;
    level  = 4'd0;
    @(posedge clk);
    started = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_anode", int'(anode), 8'hFF);
    check("reset_cathode", int'(cathode), 7'h7F);
    reset = 1'b1;
    @(negedge clk);
    check("first_anode", int'(anode), 8'hFE);
    check("first_cathode", int'(cathode), 7'b1000000);
    $display("TXN release number=0 level=0");

    number = 10'd1023;
    $display("TXN number=1023");
    repeat (20) @(negedge clk);
    expect_digit("n1023_d0", 8'hFE, 7'b0110000);
    expect_digit("n1023_d1", 8'hFD, 7'b0100100);
    expect_digit("n1023_d2", 8'hFB, 7'b1000000);
    expect_digit("n1023_d3", 8'hF7, 7'b1111001);

    number = 10'd7;
    $display("TXN number=7");
    repeat (20) @(negedge clk);
    expect_digit("n7_d0", 8'hFE, 7'b1111000);
    expect_dark("n7_d3to1_dark", 8'b0000_1110);

    level = 4'd12;
    $display("TXN level=12");
    repeat (20) @(negedge clk);
    expect_digit("l12_d7", 8'h7F, 7'b1111001);
    expect_digit("l12_d6", 8'hBF, 7'b0100100);

    level = 4'd5;
    $display("TXN level=5");
    repeat (20) @(negedge clk);
    expect_digit("l5_d6", 8'hBF, 7'b0010010);
    expect_dark("l5_d7_dark", 8'h80);

    number = 10'd500;
    repeat (3) @(negedge clk);
    number = 10'd501;
    $display("TXN number=500 then 501 after 3 cycles");
    repeat (30) @(negedge clk);
    expect_digit("n501_d0", 8'hFE, 7'b1111001);
    expect_digit("n501_d2", 8'hFB, 7'b0010010);

    number = 10'd300;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_anode", int'(anode), 8'hFF);
    check("async_rst_cathode", int'(cathode), 7'h7F);
    $display("TXN number=300 with reset mid-conversion");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (13 + SCAN_DIV) @(negedge clk);
    expect_digit("rst_n300_d2", 8'hFB, 7'b0110000);

    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (t % 3 == 0) number = 10'(NUM_PICKS[$urandom_range(0, 7)]);
      else            number = 10'($urandom_range(0, 1023));
      level = (t % 4 == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom_range(0, 15));
      hold  = $urandom_range(1, 60);
      $display("TXN rand %0d number=%0d level=%0d hold=%0d", t, number, level, hold);
      repeat (hold) @(negedge clk);
    end

    repeat (60) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
